// File: rtl/lfsr_rand_gen_if.sv
// lfsr_rand_gen_if: seed/step/request controls in, state and bounded-random result out
interface lfsr_rand_gen_if #(
  parameter int WIDTH = 10,
  parameter int OUT_W = 4
) ();
  logic [WIDTH-1:0] seed;
  logic             load;
  logic             step_en;
  logic             req;
  logic [OUT_W-1:0] limit;
  logic             busy;
  logic             valid;
  logic [OUT_W-1:0] value;
  logic             fallback;
  logic             lockup_fix;
  logic [WIDTH-1:0] state;
  modport master (output seed, load, step_en, req, limit,
                  input busy, valid, value, fallback, lockup_fix, state);
  modport slave  (input seed, load, step_en, req, limit,
                  output busy, valid, value, fallback, lockup_fix, state);
endinterface

// File: rtl/lfsr_rand_gen.sv
// lfsr_rand_gen: XNOR Fibonacci LFSR with seed load, lockup recovery and
// rejection-sampled bounded random values in [0, limit)
module lfsr_rand_gen #(
  parameter int               WIDTH   = 10,
  parameter logic [WIDTH-1:0] TAPS    = 10'b0000001001,
  parameter int               OUT_W   = 4,
  parameter int               MAX_TRY = 16
) (
  input logic           clk,
  input logic           reset,
  lfsr_rand_gen_if.slave bus
);
  localparam int CW = $clog2(MAX_TRY + 1);
  typedef enum logic {IDLE = 1'b0, SAMPLE = 1'b1} st_t;
  st_t              st, st_n;
  logic [CW-1:0]    try_cnt, try_n;
  logic [OUT_W-1:0] lim_q, lim_n, cand;
  logic             fb, lock, accept, give_up, done, do_step;
  logic [WIDTH-1:0] seed_v;
  always_comb begin
    fb      = ~^(bus.state & TAPS);
    lock    = bus.seed == '1;
    seed_v  = lock ? '0 : bus.seed;
    cand    = bus.state[OUT_W-1:0];
    accept  = lim_q == '0 || cand < lim_q;
    give_up = try_cnt == CW'(MAX_TRY - 1);
    done    = st == SAMPLE && (accept || give_up);
    do_step = st == SAMPLE || bus.step_en;
    st_n    = st == IDLE ? (bus.req ? SAMPLE : IDLE) : (done ? IDLE : SAMPLE);
    try_n   = st == IDLE ? '0 : try_cnt + 1'b1;
    lim_n   = st == IDLE && bus.req ? bus.limit : lim_q;
  end
  assign bus.busy = st == SAMPLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      st             <= IDLE;
      try_cnt        <= '0;
      lim_q          <= '0;
      bus.state      <= seed_v;
      bus.valid      <= 1'b0;
      bus.fallback   <= 1'b0;
      bus.value      <= '0;
      bus.lockup_fix <= lock;
    end else begin
      st             <= st_n;
      try_cnt        <= try_n;
      lim_q          <= lim_n;
      bus.state      <= bus.load ? seed_v : do_step ? {fb, bus.state[WIDTH-1:1]} : bus.state;
      bus.valid      <= done;
      bus.fallback   <= done && !accept;
      bus.value      <= done ? (accept ? cand : '0) : bus.value;
      bus.lockup_fix <= bus.load && lock;
    end
  end
endmodule

// File: tb/tb_lfsr_rand_gen.sv
// tb_lfsr_rand_gen: directed spec scenarios plus randomized run against a behavioural model
module tb_lfsr_rand_gen;
  localparam logic [9:0] TAPS = 10'b0000001001;
  logic clk = 0, reset = 1;
  int total = 0, bad = 0;
  lfsr_rand_gen_if #(.WIDTH(10), .OUT_W(4)) bus ();
  lfsr_rand_gen_if #(.WIDTH(10), .OUT_W(4)) bus2 ();
  lfsr_rand_gen #(.WIDTH(10), .TAPS(TAPS), .OUT_W(4), .MAX_TRY(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  lfsr_rand_gen #(.WIDTH(10), .TAPS(TAPS), .OUT_W(4), .MAX_TRY(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // next state: new top bit is 1 when an even number of tapped bits are set
  function automatic logic [9:0] nxt(input logic [9:0] s);
    return {($countones(s & TAPS) % 2 == 0) ? 1'b1 : 1'b0, s[9:1]};
  endfunction

  logic [9:0] m_state;
  logic [3:0] m_val, m_lim;
  logic       m_busy, m_valid, m_fb, m_lock;
  int         m_tries;
  bit         started = 0;
  always @(posedge clk) begin
    logic lk;
    logic [9:0] ns;
    logic [3:0] cand;
    lk = bus.seed == 10'h3FF;
    if (reset) begin
      m_state = lk ? 10'h0 : bus.seed;
      m_busy = 0; m_valid = 0; m_fb = 0; m_val = 0; m_lock = lk; started = 1;
    end else begin
      ns = bus.load ? (lk ? 10'h0 : bus.seed) : (m_busy || bus.step_en) ? nxt(m_state) : m_state;
      m_valid = 0; m_fb = 0; m_lock = bus.load && lk;
      if (m_busy) begin
        cand = m_state[3:0];
        if (m_lim == 0 || cand < m_lim) begin
          m_valid = 1; m_val = cand; m_busy = 0;
        end else begin
          m_tries++;
          if (m_tries == 16) begin
            m_valid = 1; m_fb = 1; m_val = 0; m_busy = 0;
          end
        end
      end else if (bus.req) begin
        m_busy = 1; m_tries = 0; m_lim = bus.limit;
      end
      m_state = ns;
    end
  end

  always @(negedge clk) if (started) begin
    chk("state", 32'(bus.state), 32'(m_state));
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("valid", 32'(bus.valid), 32'(m_valid));
    chk("value", 32'(bus.value), 32'(m_val));
    chk("fallback", 32'(bus.fallback), 32'(m_fb));
    chk("lockup_fix", 32'(bus.lockup_fix), 32'(m_lock));
  end

  initial begin
    int nv;
    bit early;
    bus.seed = 0; bus.load = 0; bus.step_en = 0; bus.req = 0; bus.limit = 0;
    bus2.seed = 10'h00F; bus2.load = 0; bus2.step_en = 0; bus2.req = 0; bus2.limit = 0;
    tick; tick;
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_valid", 32'(bus.valid), 0);
    reset = 0;
    // T1: sequence from zero and maximal period
    bus.step_en = 1;
    tick; chk("t1_s1", 32'(bus.state), 32'h200);
    tick; chk("t1_s2", 32'(bus.state), 32'h300);
    early = 0;
    for (int i = 3; i <= 1023; i++) begin
      tick;
      if (i < 1023 && bus.state == 0) early = 1;
    end
    chk("t1_early_repeat", 32'(early), 0);
    chk("t1_period", 32'(bus.state), 0);
    bus.step_en = 0;
    // T2: lockup seed on reset and on load
    bus.seed = 10'h3FF; reset = 1;
    tick; chk("t2_rst_state", 32'(bus.state), 0); chk("t2_rst_fix", 32'(bus.lockup_fix), 1);
    reset = 0;
    tick; chk("t2_fix_pulse", 32'(bus.lockup_fix), 0);
    bus.step_en = 1; tick; tick; bus.step_en = 0;
    chk("t2_pre_load", 32'(bus.state), 32'h300);
    bus.load = 1; tick; bus.load = 0;
    chk("t2_load_state", 32'(bus.state), 0); chk("t2_load_fix", 32'(bus.lockup_fix), 1);
    tick; chk("t2_load_pulse", 32'(bus.lockup_fix), 0);
    // T3: immediate accept
    bus.seed = 0; reset = 1; tick; reset = 0;
    bus.limit = 5; bus.req = 1; tick; bus.req = 0;
    chk("t3_busy", 32'(bus.busy), 1); chk("t3_novalid", 32'(bus.valid), 0);
    tick;
    chk("t3_valid", 32'(bus.valid), 1); chk("t3_value", 32'(bus.value), 0);
    chk("t3_fb", 32'(bus.fallback), 0); chk("t3_state", 32'(bus.state), 32'h200);
    chk("t3_idle", 32'(bus.busy), 0);
    // T4: three rejects then accept
    bus.seed = 10'h00F; reset = 1; tick; reset = 0;
    bus.limit = 3; bus.req = 1; tick; bus.req = 0;
    for (int i = 0; i < 3; i++) begin tick; chk("t4_wait", 32'(bus.valid), 0); end
    tick;
    chk("t4_valid", 32'(bus.valid), 1); chk("t4_value", 32'(bus.value), 1);
    chk("t4_state", 32'(bus.state), 32'h040);
    // T5: fallback on the MAX_TRY=2 instance
    bus2.limit = 1; bus2.req = 1; tick; bus2.req = 0;
    tick; chk("t5_wait", 32'(bus2.valid), 0);
    tick;
    chk("t5_valid", 32'(bus2.valid), 1); chk("t5_value", 32'(bus2.value), 0);
    chk("t5_fb", 32'(bus2.fallback), 1);
    tick; chk("t5_pulse", 32'(bus2.valid), 0);
    // T6: reset mid-sample, then req while busy ignored
    reset = 1; tick; reset = 0;
    bus.req = 1; tick; bus.req = 0; tick; tick;
    reset = 1; tick; reset = 0;
    chk("t6_busy", 32'(bus.busy), 0); chk("t6_valid", 32'(bus.valid), 0);
    chk("t6_state", 32'(bus.state), 32'h00F);
    bus.req = 1; tick; tick; bus.req = 0;
    nv = 0;
    for (int i = 0; i < 20; i++) begin tick; if (bus.valid) nv++; end
    chk("t6_single_valid", 32'(nv), 1);
    // randomized run
    for (int i = 0; i < 1500; i++) begin
      reset = $urandom_range(99) == 0;
      bus.load = $urandom_range(19) == 0;
      bus.seed = $urandom_range(3) == 0 ? 10'h3FF : 10'($urandom);
      bus.step_en = 1'($urandom);
      bus.req = $urandom_range(2) == 0;
      bus.limit = 4'($urandom);
      tick;
    end
    reset = 0; bus.load = 0; bus.req = 0;
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
